// File: rtl/mario_pkg.sv
// Shared sprite-motion types and default constants for the jump controller and physics module.
package mario_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HANG = 2'd2,
        FALL = 2'd3
    } jump_state_t;

    localparam int DEF_Y_W         = 10;
    localparam int DEF_RISE_V      = 2;
    localparam int DEF_MIN_RISE    = 4;
    localparam int DEF_MAX_RISE    = 15;
    localparam int DEF_HANG_FRAMES = 8;
    localparam int DEF_GRAV_DIV    = 2;
    localparam int DEF_MAX_FALL    = 4;
    localparam int DEF_BUF_FRAMES  = 3;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/jump_press_buf.sv
// Jump key edge detect plus a short airborne memory of presses so a press just before landing still jumps.
// press is combinational from jump_btn; buffered reflects the registered countdown.
module jump_press_buf
    import mario_pkg::*;
#(
    parameter int BUF_FRAMES = DEF_BUF_FRAMES
) (
    input  logic frame_clk,
    input  logic Reset_n,
    input  logic jump_btn,
    input  logic load_en,
    input  logic clear,
    output logic press,
    output logic buffered
);

    localparam int              BW       = cnt_w(BUF_FRAMES);
    localparam logic [BW-1:0]   BUF_LOAD = BW'(BUF_FRAMES);

    logic          btn_q;
    logic [BW-1:0] buf_cnt;

    assign press    = jump_btn & ~btn_q;
    assign buffered = (buf_cnt != '0);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_q   <= 1'b0;
            buf_cnt <= '0;
        end else begin
            btn_q <= jump_btn;
            if (clear) begin
                buf_cnt <= '0;
            end else if (load_en && press) begin
                buf_cnt <= BUF_LOAD;
            end else if (buf_cnt != '0) begin
                buf_cnt <= buf_cnt - BW'(1);
            end
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Per-frame vertical-motion FSM for the player sprite: variable-height rise, apex hang, accelerating fall.
// Outputs are registered alongside the state, so they describe the frame that follows each edge.
module jump_ctrl
    import mario_pkg::*;
#(
    parameter int W           = DEF_Y_W,
    parameter int RISE_V      = DEF_RISE_V,
    parameter int MIN_RISE    = DEF_MIN_RISE,
    parameter int MAX_RISE    = DEF_MAX_RISE,
    parameter int HANG_FRAMES = DEF_HANG_FRAMES,
    parameter int GRAV_DIV    = DEF_GRAV_DIV,
    parameter int MAX_FALL    = DEF_MAX_FALL,
    parameter int BUF_FRAMES  = DEF_BUF_FRAMES
) (
    input  logic                frame_clk,
    input  logic                Reset_n,
    input  logic                jump_en,
    input  logic                jump_btn,
    input  logic                on_ground,
    input  logic                head_hit,
    output logic signed [W-1:0] y_motion,
    output logic                airborne,
    output logic                apex,
    output logic [1:0]          jump_state
);

    localparam int RCW = cnt_w(MAX_RISE);
    localparam int HCW = cnt_w(HANG_FRAMES);
    localparam int GCW = cnt_w(GRAV_DIV - 1);
    localparam int FVW = cnt_w(MAX_FALL);

    localparam logic [RCW-1:0]        RISE_LAST = RCW'(MAX_RISE);
    localparam logic [RCW-1:0]        RISE_MIN  = RCW'(MIN_RISE);
    localparam logic [HCW-1:0]        HANG_LAST = HCW'(HANG_FRAMES);
    localparam logic [GCW-1:0]        GRAV_LAST = GCW'(GRAV_DIV - 1);
    localparam logic [FVW-1:0]        FALL_MAX  = FVW'(MAX_FALL);
    localparam logic signed [W-1:0]   UP_V      = W'(-RISE_V);

    if (MIN_RISE < 1 || MIN_RISE > MAX_RISE) begin : g_bad_rise
        $error("jump_ctrl: MIN_RISE must satisfy 1 <= MIN_RISE <= MAX_RISE");
    end
    if (HANG_FRAMES < 1) begin : g_bad_hang
        $error("jump_ctrl: HANG_FRAMES must be at least 1");
    end
    if (GRAV_DIV < 1) begin : g_bad_grav
        $error("jump_ctrl: GRAV_DIV must be at least 1");
    end
    if (MAX_FALL >= (1 << (W - 1)) || RISE_V >= (1 << (W - 1))) begin : g_bad_speed
        $error("jump_ctrl: MAX_FALL and RISE_V must fit in signed y_motion");
    end

    jump_state_t    state, state_n;
    logic [RCW-1:0] rise_cnt, rise_n;
    logic [HCW-1:0] hang_cnt, hang_n;
    logic [GCW-1:0] grav_cnt, grav_n;
    logic [FVW-1:0] fall_v, fall_n;
    logic           press, buffered, buf_clear;

    jump_press_buf #(
        .BUF_FRAMES (BUF_FRAMES)
    ) u_press_buf (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .jump_btn   (jump_btn),
        .load_en    (state != IDLE),
        .clear      (buf_clear),
        .press      (press),
        .buffered   (buffered)
    );

    always_comb begin
        state_n = state;
        rise_n  = rise_cnt;
        hang_n  = hang_cnt;
        grav_n  = grav_cnt;
        fall_n  = fall_v;
        case (state)
            IDLE: begin
                if (on_ground && jump_en && (press || buffered)) begin
                    state_n = RISE;
                    rise_n  = RCW'(1);
                end else if (!on_ground) begin
                    state_n = FALL;
                    fall_n  = FVW'(1);
                    grav_n  = '0;
                end
            end
            RISE: begin
                // Ceiling bump cuts the jump short and skips the apex hang.
                if (head_hit) begin
                    state_n = FALL;
                    fall_n  = FVW'(1);
                    grav_n  = '0;
                end else if (rise_cnt == RISE_LAST || (rise_cnt >= RISE_MIN && !jump_btn)) begin
                    state_n = HANG;
                    hang_n  = HCW'(1);
                end else begin
                    rise_n = rise_cnt + RCW'(1);
                end
            end
            HANG: begin
                if (hang_cnt == HANG_LAST) begin
                    state_n = FALL;
                    fall_n  = FVW'(1);
                    grav_n  = '0;
                end else begin
                    hang_n = hang_cnt + HCW'(1);
                end
            end
            FALL: begin
                if (on_ground) begin
                    state_n = IDLE;
                end else if (grav_cnt == GRAV_LAST) begin
                    grav_n = '0;
                    if (fall_v < FALL_MAX) begin
                        fall_n = fall_v + FVW'(1);
                    end
                end else begin
                    grav_n = grav_cnt + GCW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign buf_clear = (state == IDLE) && (state_n == RISE);

    function automatic logic signed [W-1:0] motion_of(input jump_state_t s, input logic [FVW-1:0] v);
        case (s)
            RISE:    return UP_V;
            FALL:    return W'(v);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            rise_cnt   <= '0;
            hang_cnt   <= '0;
            grav_cnt   <= '0;
            fall_v     <= '0;
            y_motion   <= '0;
            airborne   <= 1'b0;
            apex       <= 1'b0;
            jump_state <= IDLE;
        end else begin
            state      <= state_n;
            rise_cnt   <= rise_n;
            hang_cnt   <= hang_n;
            grav_cnt   <= grav_n;
            fall_v     <= fall_n;
            y_motion   <= motion_of(state_n, fall_n);
            airborne   <= (state_n != IDLE);
            apex       <= (state_n == HANG);
            jump_state <= state_n;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: frames are driven from directed vectors, expected outputs queued per frame.
module tb_jump_ctrl;
    import mario_pkg::*;

    logic              frame_clk = 1'b0;
    logic              Reset_n   = 1'b0;
    logic              jump_en   = 1'b1;
    logic              jump_btn  = 1'b0;
    logic              on_ground = 1'b1;
    logic              head_hit  = 1'b0;
    logic signed [9:0] y_motion;
    logic              airborne;
    logic              apex;
    logic [1:0]        jump_state;

    jump_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .jump_en    (jump_en),
        .jump_btn   (jump_btn),
        .on_ground  (on_ground),
        .head_hit   (head_hit),
        .y_motion   (y_motion),
        .airborne   (airborne),
        .apex       (apex),
        .jump_state (jump_state)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int due;
        int tag;
        int y;
        int st;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;
    int   fall_seq[8] = '{1, 2, 2, 3, 3, 4, 4, 4};

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic cmp(input int tg, input int y, input int st);
        logic       ea, ep;
        logic [1:0] es;
        ea = (st != 0);
        ep = (st == 2);
        es = st[1:0];
        checks++;
        if (int'(y_motion) != y || airborne !== ea || apex !== ep || jump_state !== es) begin
            errors++;
            $display("FAIL frame%0d: got y=%0d air=%0b apex=%0b st=%0d, need y=%0d air=%0b apex=%0b st=%0d",
                     tg, y_motion, airborne, apex, jump_state, y, ea, ep, es);
        end
    endtask

    always @(negedge frame_clk) begin
        exp_t e;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            cmp(e.tag, e.y, e.st);
        end
    end

    // One frame: apply inputs, queue the outputs expected after the next edge.
    task automatic fr(input logic btn, input logic gnd, input logic hit, input logic en,
                      input int y, input int st);
        exp_t e;
        @(posedge frame_clk);
        #1;
        jump_btn  = btn;
        on_ground = gnd;
        head_hit  = hit;
        jump_en   = en;
        tag++;
        e.due = cyc + 1;
        e.tag = tag;
        e.y   = y;
        e.st  = st;
        q.push_back(e);
    endtask

    task automatic tap_jump();
        fr(1, 1, 0, 1, -2, 1);
        repeat (3) fr(0, 1, 0, 1, -2, 1);
        repeat (8) fr(0, 1, 0, 1, 0, 2);
        fr(0, 0, 0, 1, 1, 3);
        for (int i = 0; i < 8; i++) fr(0, 0, 0, 1, fall_seq[i], 3);
        fr(0, 1, 0, 1, 0, 0);
    endtask

    initial begin
        exp_t e0;
        e0.due = 0; e0.tag = 0; e0.y = 0; e0.st = 0;
        q.push_back(e0);
        repeat (2) @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;

        // Tap
        fr(0, 1, 0, 1, 0, 0);
        tap_jump();

        // Hold: capped rise, no retrigger while still held after landing
        fr(1, 1, 0, 1, -2, 1);
        repeat (14) fr(1, 1, 0, 1, -2, 1);
        repeat (8) fr(1, 1, 0, 1, 0, 2);
        fr(1, 0, 0, 1, 1, 3);
        fr(1, 0, 0, 1, 1, 3);
        fr(1, 1, 0, 1, 0, 0);
        repeat (3) fr(1, 1, 0, 1, 0, 0);
        fr(0, 1, 0, 1, 0, 0);

        // Ceiling on the sixth rise frame
        repeat (6) fr(1, 1, 0, 1, -2, 1);
        fr(1, 1, 1, 1, 1, 3);
        fr(0, 0, 0, 1, 1, 3);
        fr(0, 1, 0, 1, 0, 0);

        // Ledge walk-off, then press two frames before landing
        fr(0, 0, 0, 1, 1, 3);
        fr(0, 0, 0, 1, 1, 3);
        fr(1, 0, 0, 1, 2, 3);
        fr(0, 0, 0, 1, 2, 3);
        fr(0, 1, 0, 1, 0, 0);
        fr(0, 1, 0, 1, -2, 1);
        repeat (3) fr(0, 1, 0, 1, -2, 1);
        repeat (8) fr(0, 1, 0, 1, 0, 2);
        fr(0, 0, 0, 1, 1, 3);
        fr(0, 1, 0, 1, 0, 0);

        // Press five frames before landing is forgotten
        fr(0, 0, 0, 1, 1, 3);
        fr(1, 0, 0, 1, 1, 3);
        fr(0, 0, 0, 1, 2, 3);
        fr(0, 0, 0, 1, 2, 3);
        fr(0, 0, 0, 1, 3, 3);
        fr(0, 0, 0, 1, 3, 3);
        fr(0, 1, 0, 1, 0, 0);
        repeat (2) fr(0, 1, 0, 1, 0, 0);

        // Gate low blocks a press on the ground
        fr(1, 1, 0, 0, 0, 0);
        fr(0, 1, 0, 0, 0, 0);
        fr(0, 1, 0, 1, 0, 0);

        // Gate dropped mid-rise does not abort the jump
        fr(1, 1, 0, 1, -2, 1);
        fr(1, 1, 0, 0, -2, 1);
        repeat (2) fr(0, 1, 0, 0, -2, 1);
        repeat (8) fr(0, 1, 0, 0, 0, 2);
        fr(0, 0, 0, 0, 1, 3);
        fr(0, 1, 0, 1, 0, 0);

        // Reset during rise frame 3 takes effect with no clock edge
        repeat (3) fr(1, 1, 0, 1, -2, 1);
        @(posedge frame_clk);
        @(negedge frame_clk);
        #1;
        Reset_n = 1'b0;
        #1;
        tag++;
        cmp(tag, 0, 0);
        jump_btn = 1'b0;
        repeat (2) @(posedge frame_clk);
        #1;
        tag++;
        cmp(tag, 0, 0);
        Reset_n = 1'b1;
        fr(0, 1, 0, 1, 0, 0);
        tap_jump();

        repeat (3) @(posedge frame_clk);
        @(negedge frame_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
